// File: rtl/kgp_subtractor_pipe.sv
// kgp_subtractor_pipe: 3-stage pipelined 16-bit subtractor, a - b - bin,
// computed as a + ~b + ~bin on a kill/generate/propagate prefix tree.
// A single stall enable freezes every register while the output is held.
module kgp_subtractor_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        zero
);

  // Pair encoding: 00 kill, 01/10 propagate, 11 generate.
  function automatic logic [1:0] kgp_comb(input logic [1:0] hi, input logic [1:0] lo);
    case (hi)
      2'b00:   return 2'b00;
      2'b11:   return 2'b11;
      default: return lo;
    endcase
  endfunction

  logic              en;
  logic [3:1]        vld_pipe;
  logic [16:0][1:0]  enc, s1, l1, l2, s2, l4, l8, l16;
  logic [15:0]       h2;
  logic              a15_2;
  logic [16:0]       c;
  logic [15:0]       d_nx;
  logic              ovf_nx;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[3];

  // KGP-encode operands; position 0 carries the inverted borrow-in.
  always_comb begin
    enc    = '0;
    enc[0] = {~bin, ~bin};
    for (int i = 0; i < 16; i++) enc[i+1] = {a[i], ~b[i]};
  end

  // Prefix levels at distances 1 and 2 (feed stage 2).
  always_comb begin
    l1 = s1;
    for (int i = 1; i < 17; i++) l1[i] = kgp_comb(s1[i], s1[i-1]);
    l2 = l1;
    for (int i = 2; i < 17; i++) l2[i] = kgp_comb(l1[i], l1[i-2]);
  end

  // Prefix levels at distances 4 and 8, then fold position 0 into position 16:
  // spans 1+2+4+8 leave the top position one short of the carry-in, which
  // matters when every operand bit propagates (e.g. a == b).
  always_comb begin
    l4 = s2;
    for (int i = 4; i < 17; i++) l4[i] = kgp_comb(s2[i], s2[i-4]);
    l8 = l4;
    for (int i = 8; i < 17; i++) l8[i] = kgp_comb(l4[i], l4[i-8]);
    l16     = l8;
    l16[16] = kgp_comb(l8[16], l8[0]);
  end

  // Carry extraction and result formation for the output register.
  always_comb begin
    c = '0;
    for (int i = 0; i < 17; i++) c[i] = l16[i][1] & l16[i][0];
    d_nx   = h2 ^ c[15:0];
    // a[15] != b[15] is equivalent to a[15] == ~b[15], i.e. half-sum bit 15 clear.
    ovf_nx = !h2[15] && (d_nx[15] != a15_2);
  end

  // Pipeline registers; data loads only with a valid beat so outputs hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      h2       <= '0;
      a15_2    <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[2:1], in_valid};
      if (in_valid) s1 <= enc;
      if (vld_pipe[1]) begin
        s2    <= l2;
        a15_2 <= s1[16][1];
        for (int i = 0; i < 16; i++) h2[i] <= s1[i+1][1] ^ s1[i+1][0];
      end
      if (vld_pipe[2]) begin
        diff <= d_nx;
        bout <= ~c[16];
        ovf  <= ovf_nx;
        zero <= (d_nx == 16'h0000);
      end
    end
  end

endmodule

// File: tb/tb_kgp_subtractor_pipe.sv
// Bench for kgp_subtractor_pipe: directed table, stall/reset sequences and
// a randomized handshake run against an arithmetic reference model.
module tb_kgp_subtractor_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] diff;
  logic        bout, ovf, zero;

  int nvec = 0;
  int nerr = 0;

  kgp_subtractor_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        bin;
    logic [15:0] diff;
    logic        bout, ovf, zero;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result packed {diff,bout,ovf,zero}.
  function automatic logic [18:0] ref_model(input logic [15:0] ra, input logic [15:0] rb, input logic rbin);
    int u, s;
    logic [15:0] d;
    u = int'(ra) - int'(rb) - int'(rbin);
    s = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
    d = u[15:0];
    return {d, u < 0, (s > 32767) || (s < -32768), d == 16'h0000};
  endfunction

  // Send one beat and check latency and result against the expected record.
  task automatic send_one(input vec_t v, input string tag);
    int k;
    @(negedge clk);
    a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 10) begin
      k++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, k, 2);
    chk({tag, "_diff"}, diff, v.diff);
    chk({tag, "_bout"}, bout, v.bout);
    chk({tag, "_ovf"},  ovf,  v.ovf);
    chk({tag, "_zero"}, zero, v.zero);
  endtask

  vec_t tbl[10];
  vec_t x, y, z;
  logic [18:0] q[$];
  logic [18:0] e;
  int acc, cyc, seen;

  initial begin
    tbl[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};

    // Reset state.
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {diff, bout, ovf, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 10; i++) send_one(tbl[i], $sformatf("tbl%0d", i));

    // Stall: X, Y, Z back to back, output held for two cycles after X appears.
    x = '{16'h00F0, 16'h0010, 1'b0, 16'h00E0, 1'b0, 1'b0, 1'b0};
    y = '{16'h0010, 16'h0020, 1'b1, 16'hFFEF, 1'b1, 1'b0, 1'b0};
    z = '{16'h4000, 16'h4000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    out_ready = 1'b1;
    a = x.a; b = x.b; bin = x.bin; in_valid = 1'b1;
    @(negedge clk);
    a = y.a; b = y.b; bin = y.bin;
    @(negedge clk);
    a = z.a; b = z.b; bin = z.bin; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_vld0", out_valid, 1);
    chk("stall_rdy0", in_ready, 0);
    chk("stall_x0", {diff, bout, ovf, zero}, {x.diff, x.bout, x.ovf, x.zero});
    @(negedge clk);
    chk("stall_vld1", out_valid, 1);
    chk("stall_rdy1", in_ready, 0);
    chk("stall_x1", {diff, bout, ovf, zero}, {x.diff, x.bout, x.ovf, x.zero});
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_y_vld", out_valid, 1);
    chk("stall_y", {diff, bout, ovf, zero}, {y.diff, y.bout, y.ovf, y.zero});
    @(negedge clk);
    chk("stall_z_vld", out_valid, 1);
    chk("stall_z", {diff, bout, ovf, zero}, {z.diff, z.bout, z.ovf, z.zero});
    @(negedge clk);
    chk("stall_drain", out_valid, 0);

    // Reset mid-stream with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      a = tbl[i+3].a; b = tbl[i+3].b; bin = tbl[i+3].bin; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_outs", {diff, bout, ovf, zero}, 0);
    chk("mrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mrst_no_stale", seen, 0);
    send_one(tbl[4], "post_rst");

    // Randomized handshake against the reference model.
    acc = 0; cyc = 0;
    q.delete();
    while ((acc < 10000 || q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (acc < 10000) && ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
      bin       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_extra_beat", 1, 0);
        else begin
          e = q.pop_front();
          chk("rand", {diff, bout, ovf, zero}, e);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_model(a, b, bin));
        acc++;
      end
    end
    in_valid = 1'b0;
    chk("rand_all_drained", q.size(), 0);
    chk("rand_accepted", acc, 10000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
